// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: hazard FSM states, stall causes and default penalties.
package pipe_pkg;

  typedef enum logic [1:0] {
    HZ_IDLE    = 2'd0,
    HZ_STALL   = 2'd1,
    HZ_MEMWAIT = 2'd2
  } hz_state_e;

  typedef enum logic {
    CAUSE_LOAD = 1'b0,
    CAUSE_FLAG = 1'b1
  } hz_cause_e;

  localparam int REG_ZERO     = 0;
  localparam int DEF_LOAD_LAT = 1;
  localparam int DEF_FLAG_LAT = 1;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones, cleared only by reset.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-to-use / flag-to-branch stall controller with memory-busy freeze and per-cause stall counters.
// Stall/bubble/freeze are combinational from the current inputs and registered FSM state.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W     = 4,
  parameter int LOAD_LAT  = DEF_LOAD_LAT,
  parameter int FLAG_LAT  = DEF_FLAG_LAT,
  parameter bit STORE_FWD = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_sets_flags,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_store,
  input  logic             id_branch_cond,
  input  logic             mem_busy,
  output logic             stall_front,
  output logic             bubble_ex,
  output logic             freeze_back,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] flag_stall_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
);

  localparam logic [3:0] LOAD_RELOAD = 4'(LOAD_LAT - 1);
  localparam logic [3:0] FLAG_RELOAD = 4'(FLAG_LAT - 1);

  hz_state_e  state_q, state_d, ret_q, ret_d, eff_state;
  hz_cause_e  cause_q, cause_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rs_hit, rt_hit, load_hit, flag_hit;
  logic       inc_load, inc_flag, inc_mem;

  // A store's data operand can be forwarded MEM-to-MEM, so it need not wait on the load.
  assign rs_hit   = id_rs_used && (ex_rd == id_rs);
  assign rt_hit   = id_rt_used && (ex_rd == id_rt) && !(STORE_FWD && id_store);
  assign load_hit = ex_mem_read && (ex_rd != REG_W'(REG_ZERO)) && (rs_hit || rt_hit);
  assign flag_hit = id_branch_cond && ex_sets_flags;

  // The cycle memory goes ready is handled exactly as the state being resumed.
  assign eff_state = ((state_q == HZ_MEMWAIT) && !mem_busy) ? ret_q : state_q;

  always_comb begin
    state_d     = eff_state;
    ret_d       = ret_q;
    cause_d     = cause_q;
    cnt_d       = cnt_q;
    stall_front = 1'b0;
    bubble_ex   = 1'b0;
    freeze_back = 1'b0;
    inc_load    = 1'b0;
    inc_flag    = 1'b0;
    inc_mem     = 1'b0;
    case (eff_state)
      HZ_IDLE: begin
        if (mem_busy) begin
          stall_front = 1'b1;
          freeze_back = 1'b1;
          inc_mem     = 1'b1;
          ret_d       = HZ_IDLE;
          state_d     = HZ_MEMWAIT;
        end else if (load_hit) begin
          stall_front = 1'b1;
          bubble_ex   = 1'b1;
          inc_load    = 1'b1;
          cause_d     = CAUSE_LOAD;
          if (LOAD_LAT > 1) begin
            cnt_d   = LOAD_RELOAD;
            state_d = HZ_STALL;
          end
        end else if (flag_hit) begin
          stall_front = 1'b1;
          bubble_ex   = 1'b1;
          inc_flag    = 1'b1;
          cause_d     = CAUSE_FLAG;
          if (FLAG_LAT > 1) begin
            cnt_d   = FLAG_RELOAD;
            state_d = HZ_STALL;
          end
        end
      end
      HZ_STALL: begin
        stall_front = 1'b1;
        if (mem_busy) begin
          freeze_back = 1'b1;
          inc_mem     = 1'b1;
          ret_d       = HZ_STALL;
          state_d     = HZ_MEMWAIT;
        end else begin
          bubble_ex = 1'b1;
          inc_load  = (cause_q == CAUSE_LOAD);
          inc_flag  = (cause_q == CAUSE_FLAG);
          cnt_d     = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = HZ_IDLE;
          end
        end
      end
      HZ_MEMWAIT: begin
        stall_front = 1'b1;
        freeze_back = 1'b1;
        inc_mem     = 1'b1;
      end
      default: begin
        state_d = HZ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HZ_IDLE;
      ret_q   <= HZ_IDLE;
      cause_q <= CAUSE_LOAD;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_load_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (inc_load),
    .cnt_o (load_stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flag_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (inc_flag),
    .cnt_o (flag_stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_mem_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (inc_mem),
    .cnt_o (mem_wait_cnt)
  );

endmodule
